// File: rtl/neuron_controller.sv
// rtl/neuron_controller.sv - sequencer feeding one neuron's MAC unit from a weight/bias memory
// Streams INPUT_SIZE activations, then the bias, then holds the result until taken downstream.
module neuron_controller #(
   parameter int WORD_SIZE  = 16,
   parameter int INPUT_SIZE = 8,
   localparam int ADDR_WIDTH = $clog2(INPUT_SIZE + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WORD_SIZE-1:0]  data_i,
   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]  lu_data_o,
   output logic                  lu_sum_en_o,
   output logic                  lu_add_bias_o,
   output logic                  lu_clear_o,
   input  logic [WORD_SIZE-1:0]  lu_result_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WORD_SIZE-1:0]  data_o
);

   typedef enum logic [2:0] {CLEAR, ACCUM, BIAS, WAIT, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INPUT_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] BIAS_ADDR = ADDR_WIDTH'(INPUT_SIZE);

   state_t                  state_r, state_n;
   logic [ADDR_WIDTH-1:0]   count_r, count_n;
   logic                    load;
   logic                    sum_n;
   logic                    bias_n;

   // Saturation lives in the logical unit; the result is passed straight through.
   assign data_o = lu_result_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r       <= CLEAR;
         count_r       <= '0;
         lu_data_o     <= '0;
         lu_sum_en_o   <= 1'b0;
         lu_add_bias_o <= 1'b0;
      end else begin
         state_r       <= state_n;
         count_r       <= count_n;
         if (load)
            lu_data_o  <= data_i;
         lu_sum_en_o   <= sum_n;
         lu_add_bias_o <= bias_n;
      end
   end

   always_comb begin
      state_n    = state_r;
      count_n    = count_r;
      ready_o    = 1'b0;
      mem_en_o   = 1'b0;
      mem_addr_o = count_r;
      lu_clear_o = 1'b0;
      valid_o    = 1'b0;
      load       = 1'b0;
      sum_n      = 1'b0;
      bias_n     = 1'b0;
      case (state_r)
         CLEAR: begin
            lu_clear_o = 1'b1;
            state_n    = ACCUM;
         end
         ACCUM: begin
            ready_o = 1'b1;
            if (valid_i) begin
               mem_en_o = 1'b1;
               load     = 1'b1;
               sum_n    = 1'b1;
               if (count_r == LAST_ADDR) begin
                  count_n = '0;
                  state_n = BIAS;
               end else begin
                  count_n = count_r + ADDR_WIDTH'(1);
               end
            end
         end
         // Memory data for the bias arrives during WAIT, when the add is enabled.
         BIAS: begin
            mem_en_o   = 1'b1;
            mem_addr_o = BIAS_ADDR;
            sum_n      = 1'b1;
            bias_n     = 1'b1;
            state_n    = WAIT;
         end
         WAIT: begin
            state_n = DONE;
         end
         DONE: begin
            valid_o = 1'b1;
            if (ready_i)
               state_n = CLEAR;
         end
         default: begin
            state_n = CLEAR;
         end
      endcase
   end

endmodule

// File: tb/tb_neuron_controller.sv
// tb/tb_neuron_controller.sv - directed bench for neuron_controller
// Two instances (INPUT_SIZE 4 and 1), each with a synchronous memory and a Q8.8 saturating MAC.
module tb_neuron_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic        valid_drv = 1'b0;
   logic        rdy_drv = 1'b0;
   logic [15:0] data_drv = 16'h0;

   logic        a_valid_i, a_ready, a_mem_en, a_sum, a_bias, a_clear, a_valid_o, a_ready_i;
   logic [2:0]  a_addr;
   logic [15:0] a_lu_data, a_acc, a_data_o, a_mem_q;
   logic        b_valid_i, b_ready, b_mem_en, b_sum, b_bias, b_clear, b_valid_o, b_ready_i;
   logic [0:0]  b_addr;
   logic [15:0] b_lu_data, b_acc, b_data_o, b_mem_q;

   logic [15:0] mem_a [0:4];
   logic [15:0] mem_b [0:1];

   assign a_valid_i = valid_drv & ~sel;
   assign b_valid_i = valid_drv & sel;
   assign a_ready_i = rdy_drv & ~sel;
   assign b_ready_i = rdy_drv & sel;

   logic        o_valid, o_ready, o_mem_en, o_sum;
   logic [2:0]  o_addr;
   logic [15:0] o_data;
   assign o_valid  = sel ? b_valid_o : a_valid_o;
   assign o_ready  = sel ? b_ready : a_ready;
   assign o_mem_en = sel ? b_mem_en : a_mem_en;
   assign o_sum    = sel ? b_sum : a_sum;
   assign o_addr   = sel ? {2'b00, b_addr} : a_addr;
   assign o_data   = sel ? b_data_o : a_data_o;

   neuron_controller #(.WORD_SIZE(16), .INPUT_SIZE(4)) dut_a (
      .clk_i(clk), .reset_i(rst), .valid_i(a_valid_i), .ready_o(a_ready), .data_i(data_drv),
      .mem_en_o(a_mem_en), .mem_addr_o(a_addr), .lu_data_o(a_lu_data), .lu_sum_en_o(a_sum),
      .lu_add_bias_o(a_bias), .lu_clear_o(a_clear), .lu_result_i(a_acc), .valid_o(a_valid_o),
      .ready_i(a_ready_i), .data_o(a_data_o)
   );

   neuron_controller #(.WORD_SIZE(16), .INPUT_SIZE(1)) dut_b (
      .clk_i(clk), .reset_i(rst), .valid_i(b_valid_i), .ready_o(b_ready), .data_i(data_drv),
      .mem_en_o(b_mem_en), .mem_addr_o(b_addr), .lu_data_o(b_lu_data), .lu_sum_en_o(b_sum),
      .lu_add_bias_o(b_bias), .lu_clear_o(b_clear), .lu_result_i(b_acc), .valid_o(b_valid_o),
      .ready_i(b_ready_i), .data_o(b_data_o)
   );

   function automatic logic [15:0] sat16(input longint v);
      if (v > 32767)
         return 16'h7FFF;
      else if (v < -32768)
         return 16'h8000;
      else
         return v[15:0];
   endfunction

   function automatic logic [15:0] mac(input logic [15:0] acc, input logic [15:0] d,
                                       input logic [15:0] w, input logic add_bias);
      longint term;
      if (add_bias)
         term = longint'($signed(w));
      else
         term = (longint'($signed(d)) * longint'($signed(w))) >>> 8;
      return sat16(longint'($signed(acc)) + term);
   endfunction

   always @(posedge clk) begin
      if (a_mem_en) a_mem_q <= mem_a[a_addr];
      if (a_clear) a_acc <= 16'h0;
      else if (a_sum) a_acc <= mac(a_acc, a_lu_data, a_mem_q, a_bias);
      if (b_mem_en) b_mem_q <= mem_b[b_addr];
      if (b_clear) b_acc <= 16'h0;
      else if (b_sum) b_acc <= mac(b_acc, b_lu_data, b_mem_q, b_bias);
   end

   int checks = 0;
   int errors = 0;
   logic [2:0] addr_log [0:7];
   int n_addr, sums, lat;

   // Called just after a falling edge; returns #1 after the falling edge where valid_o is first seen.
   task automatic run_vec(input logic s, input logic [15:0] dval, input bit gap);
      int cyc, beats, nb, last_beat;
      sel = s;
      nb = s ? 1 : 4;
      n_addr = 0; sums = 0; cyc = 0; beats = 0; last_beat = -100;
      rdy_drv = 1'b0;
      data_drv = dval;
      while (cyc < 100) begin
         valid_drv = (beats < nb) && (!gap || (cyc % 2 == 1));
         #1;
         if (o_valid) break;
         if (o_mem_en && n_addr < 8) begin
            addr_log[n_addr] = o_addr;
            n_addr++;
         end
         if (o_sum) sums++;
         if (valid_drv && o_ready) begin
            beats++;
            last_beat = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      valid_drv = 1'b0;
      lat = cyc - last_beat;
      checks++;
      if (!o_valid) begin
         errors++;
         $display("FAIL run_timeout: valid_o=%b after %0d cycles, required 1", o_valid, cyc);
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      rdy_drv = 1'b1;
      @(negedge clk);
      rdy_drv = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_valid: got %b, required 0", o_valid);
      end
   endtask

   task automatic check_addrs(input int n);
      checks++;
      if (n_addr != n) begin
         errors++;
         $display("FAIL addr_count: got %0d, required %0d", n_addr, n);
      end
      for (int i = 0; i < n && i < n_addr; i++) begin
         checks++;
         if (addr_log[i] !== 3'(i)) begin
            errors++;
            $display("FAIL mem_addr[%0d]: got %0d, required %0d", i, addr_log[i], i);
         end
      end
   endtask

   task automatic check_result(input string name, input logic [15:0] exp_data);
      checks++;
      if (o_data !== exp_data) begin
         errors++;
         $display("FAIL %s data_o: got %h, required %h", name, o_data, exp_data);
      end
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL %s latency: got %0d, required 3", name, lat);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({a_ready, a_valid_o, a_mem_en, a_sum, a_bias, a_clear} !== 6'b000001) begin
         errors++;
         $display("FAIL %s ctrl {ready,valid,mem_en,sum,bias,clear}: got %b, required 000001", name,
                  {a_ready, a_valid_o, a_mem_en, a_sum, a_bias, a_clear});
      end
      checks++;
      if (a_lu_data !== 16'h0 || a_addr !== 3'd0) begin
         errors++;
         $display("FAIL %s lu_data/addr: got %h/%0d, required 0000/0", name, a_lu_data, a_addr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (a_clear !== 1'b1 || a_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_clear: clear/ready got %b/%b, required 1/0", a_clear, a_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (a_ready !== 1'b1 || a_clear !== 1'b0) begin
         errors++;
         $display("FAIL reset_then_accum: ready/clear got %b/%b, required 1/0", a_ready, a_clear);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      run_vec(1'b0, 16'h0200, 1'b0);
      check_addrs(5);
      check_result("b2b", 16'h0880);
      release_out();
   endtask

   task automatic test_stall();
      run_vec(1'b0, 16'h0200, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_mem_en !== 1'b0 || o_data !== 16'h0880) begin
            errors++;
            $display("FAIL stall[%0d]: valid/ready/mem_en/data got %b/%b/%b/%h, required 1/0/0/0880",
                     i, o_valid, o_ready, o_mem_en, o_data);
         end
      end
      release_out();
   endtask

   task automatic test_gaps();
      run_vec(1'b0, 16'h0200, 1'b1);
      check_addrs(5);
      check_result("gaps", 16'h0880);
      checks++;
      if (sums != 5) begin
         errors++;
         $display("FAIL gaps_sum_pulses: got %0d, required 5", sums);
      end
      release_out();
   endtask

   task automatic test_midreset();
      int beats, cyc;
      sel = 1'b0; rdy_drv = 1'b0; data_drv = 16'h0200; beats = 0; cyc = 0;
      @(negedge clk);
      while (beats < 2 && cyc < 50) begin
         valid_drv = 1'b1;
         #1;
         if (a_ready) beats++;
         @(negedge clk);
         cyc++;
      end
      valid_drv = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (a_clear !== 1'b1) begin
         errors++;
         $display("FAIL midreset_clear: got %b, required 1", a_clear);
      end
      @(negedge clk);
      run_vec(1'b0, 16'h0200, 1'b0);
      check_addrs(5);
      check_result("midreset", 16'h0880);
      release_out();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) mem_a[i] = 16'h7F00;
      run_vec(1'b0, 16'h7F00, 1'b0);
      check_result("sat_pos", 16'h7FFF);
      release_out();
      for (int i = 0; i < 4; i++) mem_a[i] = 16'h8100;
      mem_a[4] = 16'h8000;
      run_vec(1'b0, 16'h7F00, 1'b0);
      check_result("sat_neg", 16'h8000);
      release_out();
   endtask

   task automatic test_single_input();
      run_vec(1'b1, 16'h0100, 1'b0);
      check_addrs(2);
      check_result("single", 16'h0200);
      release_out();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mem_a[i] = 16'h0100;
      mem_a[4] = 16'h0080;
      mem_b[0] = 16'h0100;
      mem_b[1] = 16'h0100;
      test_reset();
      test_back_to_back();
      test_stall();
      test_gaps();
      test_midreset();
      test_saturation();
      test_single_input();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
